// File: rtl/imem_loader_if.sv
// Byte-stream handshake into the instruction-memory loader.
// Source drives data/valid, loader answers with ready.
interface imem_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian program into imem, holding the CPU.
// Optional: IMEM_LOADER_CHECKSUM_EN appends and verifies an XOR checksum word.
module imem_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  imem_loader_if.slave      strm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, LEN, DATA, WRITE, CSUM, DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, LEN, DATA, WRITE, DONE
  } state_t;
`endif

  state_t      state;
  logic [1:0]  bcnt;
  logic [31:0] shreg;
  logic [31:0] len;
  logic [31:0] word;
  logic [31:0] wl_next;
  logic        xfer;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] csum;
`endif

  // New bytes enter at the top so the first byte ends in [7:0].
  assign word    = {strm.in_data, shreg[31:8]};
  assign xfer    = strm.in_valid && strm.in_ready;
  assign wl_next = 32'(words_loaded) + 32'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bcnt          <= '0;
      shreg         <= '0;
      len           <= '0;
      strm.in_ready <= 1'b0;
      mem_we        <= 1'b0;
      mem_waddr     <= '0;
      mem_wdata     <= '0;
      cpu_hold      <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      words_loaded  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= LEN;
            strm.in_ready <= 1'b1;
            cpu_hold      <= 1'b1;
            done          <= 1'b0;
            err           <= 1'b0;
            words_loaded  <= '0;
            bcnt          <= '0;
            shreg         <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum          <= '0;
`endif
          end
        end
        LEN: begin
          if (xfer) begin
            shreg <= word;
            bcnt  <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              len <= word;
              if (word > 32'(DEPTH)) begin
                err           <= 1'b1;
                state         <= DONE;
                strm.in_ready <= 1'b0;
                cpu_hold      <= 1'b0;
                done          <= 1'b1;
              end else if (word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state         <= CSUM;
`else
                state         <= DONE;
                strm.in_ready <= 1'b0;
                cpu_hold      <= 1'b0;
                done          <= 1'b1;
`endif
              end else begin
                state <= DATA;
              end
            end
          end
        end
        DATA: begin
          if (xfer) begin
            shreg <= word;
            bcnt  <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              state         <= WRITE;
              strm.in_ready <= 1'b0;
              mem_we        <= 1'b1;
              mem_waddr     <= words_loaded[ADDR_W-1:0];
              mem_wdata     <= word;
`ifdef IMEM_LOADER_CHECKSUM_EN
              csum          <= csum ^ word;
`endif
            end
          end
        end
        WRITE: begin
          words_loaded <= wl_next[ADDR_W:0];
          if (wl_next == len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state         <= CSUM;
            strm.in_ready <= 1'b1;
`else
            state         <= DONE;
            cpu_hold      <= 1'b0;
            done          <= 1'b1;
`endif
          end else begin
            state         <= DATA;
            strm.in_ready <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: begin
          if (xfer) begin
            shreg <= word;
            bcnt  <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              if (word != csum) err <= 1'b1;
              state         <= DONE;
              strm.in_ready <= 1'b0;
              cpu_hold      <= 1'b0;
              done          <= 1'b1;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the core's instruction ROM: loads a program into instruction memory before execution.
- Accepts a little-endian byte stream over a valid/ready handshake. The stream is a 32-bit word count followed by that many 32-bit instruction words.
- Each assembled word is written through a single-cycle write port, one word per write.
- Holds the CPU off (cpu_hold) for the whole load, so the core never fetches a half-loaded program.

Parameters:
- DEPTH, 16, number of 32-bit words in instruction memory.
- ADDR_W, 4, word-address width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a load when in IDLE or DONE.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction-memory write enable, one cycle per word.
- mem_waddr  output  ADDR_W  word index being written (byte address = index*4).
- mem_wdata  output  32  instruction word.
- cpu_hold  output  1  keeps the core in reset/stall while loading.
- done  output  1  load finished; sticky until next start.
- err  output  1  load rejected or failed; sticky until next start.
- words_loaded  output  ADDR_W+1  count of words written in the current/last load.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - All outputs 0: in_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, done, err, words_loaded.
  - Byte counter and shift register cleared.
  - Reset mid-load aborts immediately; no further writes occur.
- Handshake: a byte transfers on a clk edge where in_valid && in_ready. in_ready is 1 only in LEN and DATA; 0 in IDLE, WRITE, DONE.
- Byte packing: little-endian. The first accepted byte lands in bits [7:0], the fourth in [31:24]. The byte counter is 2 bits and wraps 3->0.
- States:
  - IDLE: on start -> LEN. Same edge: cpu_hold<=1, done<=0, err<=0, words_loaded<=0.
  - LEN: collect 4 bytes into len.
    - On the 4th byte: len==0 -> DONE.
    - len>DEPTH -> err<=1, DONE. No writes; the remaining stream is not consumed.
    - Otherwise -> DATA.
  - DATA: collect 4 bytes; on the 4th byte -> WRITE.
  - WRITE: held exactly one cycle.
    - mem_we=1, mem_waddr=words_loaded[ADDR_W-1:0], mem_wdata=assembled word.
    - Next edge: words_loaded+1.
    - If words_loaded+1==len -> DONE, else -> DATA.
  - DONE: cpu_hold<=0 on entry, done=1. start -> LEN with the same side effects as from IDLE.
- start is ignored in LEN, DATA and WRITE.
- Latency: the write pulse occurs the cycle after the 4th byte of each word is accepted. After the final write, done=1 and cpu_hold=0 on the next edge.
- mem_we is never high for two consecutive cycles.
- mem_waddr and mem_wdata hold their last values when mem_we=0.
- in_valid is ignored when in_ready=0.
- len is 32-bit unsigned; the comparison is against DEPTH as a full 32-bit value.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN
- With the macro defined:
  - After the last data word, the stream carries one more 32-bit word: the XOR of all data words.
  - A CSUM state collects it; in_ready=1 in CSUM.
  - Running XOR resets to 0 at start.
  - Mismatch: err<=1 and done<=1 on entry to DONE. Words already written stay in memory.
  - Match: err stays 0.
  - len==0 still requires a checksum word of 0x00000000.
- Without the macro: there is no CSUM state. The transition goes straight to DONE after the last WRITE, and err is driven only by the len>DEPTH check.

Test Plan:
- Reset behaviour: assert rst mid-DATA (after 2 bytes of word 1) -> mem_we stays 0; all outputs 0. Then a fresh start and 1-word load of 0x00500093 -> single write to index 0.
- Three-word load: start, bytes 03 00 00 00, 93 00 50 00, 13 01 50 00, 63 84 20 00, in_valid held 1:
  - Writes 0x00500093@0, 0x00500113@1, 0x00208463@2, each a single-cycle mem_we.
  - words_loaded=3, done=1, cpu_hold=0 one cycle after the last write.
- Backpressure and gaps: same stream with in_valid toggled every other cycle -> identical writes. in_ready=0 during each WRITE cycle; no byte is lost or duplicated.
- Bounds:
  - len=0 -> done=1, no writes.
  - len=17 with DEPTH=16 -> err=1, done=1, no writes.
  - len=16 -> 16 writes to indices 0..15, err=0.
- start during LEN or DATA is ignored. start in DONE clears done, err and words_loaded and reloads correctly.
- With IMEM_LOADER_CHECKSUM_EN:
  - 2 words 0x00500093, 0x00500113 plus checksum 0x00000180 -> err=0.
  - Checksum 0x00000181 -> err=1, done=1, both words still written.
